// File: rtl/scope_capture_buffer.sv
// scope_capture_buffer: decimating, triggered writer for the 256-sample
// trace array, double-buffered and swapped on vertical blank.
module scope_capture_buffer #(
  parameter int unsigned DEPTH        = 256,
  parameter int unsigned AUTO_TIMEOUT = 4096,
  parameter logic [11:0] MIDSCALE     = 12'd2047
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [11:0] adc_data,
  input  logic        adc_valid,
  input  logic [3:0]  decimation,
  input  logic [11:0] trigger_level,
  input  logic        trigger_falling,
  input  logic        vblnk,
  output logic [11:0] data_display [0:DEPTH-1],
  output logic        frame_ready,
  output logic        capturing,
  output logic        auto_triggered
);

  localparam int AW = $clog2(DEPTH);
  localparam int TW = $clog2(AUTO_TIMEOUT);

  typedef enum logic [1:0] {
    ARMED,
    CAPTURE,
    DONE
  } state_t;

  state_t        state;
  logic [3:0]    dec_cnt;
  logic [3:0]    dec_lat;
  logic [AW-1:0] idx;
  logic [TW-1:0] tmo_cnt;
  logic [11:0]   prev;
  logic          prev_valid;
  logic          auto_flag;
  logic          front;
  logic          vblnk_q;

  logic [11:0]   bank0 [0:DEPTH-1];
  logic [11:0]   bank1 [0:DEPTH-1];

  logic          accept;
  logic          vblnk_rise;
  logic          rise_hit;
  logic          fall_hit;
  logic          hit;
  logic          timeout;
  logic          swap;
  logic          wr_en;
  logic [AW-1:0] wr_addr;

  // Accept/trigger/write decode for the current cycle
  always_comb begin
    accept     = adc_valid && (dec_cnt == dec_lat);
    vblnk_rise = vblnk && !vblnk_q;
    rise_hit   = prev_valid && (prev < trigger_level)
                 && (adc_data >= trigger_level);
    fall_hit   = prev_valid && (prev > trigger_level)
                 && (adc_data <= trigger_level);
    hit        = trigger_falling ? fall_hit : rise_hit;
    timeout    = (tmo_cnt == TW'(AUTO_TIMEOUT - 1));
    swap       = (state == DONE) && vblnk_rise;
    wr_en      = 1'b0;
    wr_addr    = idx;
    unique case (state)
      ARMED: begin
        if (accept && (hit || timeout)) begin
          wr_en   = 1'b1;
          wr_addr = '0;
        end
      end
      CAPTURE: wr_en = accept;
      default: wr_en = 1'b0;
    endcase
  end

  // Decimation counter; the ratio is relatched only at each wrap
  always_ff @(posedge clk) begin
    if (rst) begin
      dec_cnt <= '0;
      dec_lat <= decimation;
    end else if (adc_valid) begin
      if (accept) begin
        dec_cnt <= '0;
        dec_lat <= decimation;
      end else begin
        dec_cnt <= dec_cnt + 4'd1;
      end
    end
  end

  // Registered vblnk for edge detection
  always_ff @(posedge clk) begin
    if (rst) vblnk_q <= 1'b0;
    else     vblnk_q <= vblnk;
  end

  // Arm / capture / wait-for-blank sequencer with registered flags
  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= ARMED;
      idx            <= '0;
      tmo_cnt        <= '0;
      prev           <= '0;
      prev_valid     <= 1'b0;
      auto_flag      <= 1'b0;
      front          <= 1'b0;
      frame_ready    <= 1'b0;
      capturing      <= 1'b0;
      auto_triggered <= 1'b0;
    end else begin
      frame_ready <= 1'b0;
      unique case (state)
        ARMED: begin
          if (accept) begin
            prev       <= adc_data;
            prev_valid <= 1'b1;
            if (hit || timeout) begin
              auto_flag <= !hit;
              idx       <= AW'(1);
              tmo_cnt   <= '0;
              capturing <= 1'b1;
              state     <= CAPTURE;
            end else begin
              tmo_cnt <= tmo_cnt + TW'(1);
            end
          end
        end
        CAPTURE: begin
          if (accept) begin
            idx <= idx + AW'(1);
            if (idx == AW'(DEPTH - 1)) begin
              capturing <= 1'b0;
              state     <= DONE;
            end
          end
        end
        DONE: begin
          if (vblnk_rise) begin
            front          <= ~front;
            frame_ready    <= 1'b1;
            auto_triggered <= auto_flag;
            auto_flag      <= 1'b0;
            tmo_cnt        <= '0;
            // a sample landing on the swap edge only seeds prev
            prev_valid     <= accept;
            if (accept) prev <= adc_data;
            state          <= ARMED;
          end
        end
        default: state <= ARMED;
      endcase
    end
  end

  // Back-bank write port; the front bank is never touched
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        bank0[i] <= MIDSCALE;
        bank1[i] <= MIDSCALE;
      end
    end else if (wr_en) begin
      if (front) bank0[wr_addr] <= adc_data;
      else       bank1[wr_addr] <= adc_data;
    end
  end

  // Display copy of the front bank, reloaded from the back at swap
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < int'(DEPTH); i++)
        data_display[i] <= MIDSCALE;
    end else if (swap) begin
      for (int i = 0; i < int'(DEPTH); i++)
        data_display[i] <= front ? bank0[i] : bank1[i];
    end
  end

endmodule

// File: tb/tb_scope_capture_buffer.sv
// tb_scope_capture_buffer: randomized and directed stimulus against a
// frame-level reference model of the capture buffer.
module tb_scope_capture_buffer;

  localparam int AUTO = 4096;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [11:0] adc_data = '0;
  logic        adc_valid = 1'b0;
  logic [3:0]  decimation = '0;
  logic [11:0] trigger_level = 12'd1000;
  logic        trigger_falling = 1'b0;
  logic        vblnk = 1'b0;
  logic [11:0] data_display [0:255];
  logic        frame_ready;
  logic        capturing;
  logic        auto_triggered;

  scope_capture_buffer dut (
    .clk            (clk),
    .rst            (rst),
    .adc_data       (adc_data),
    .adc_valid      (adc_valid),
    .decimation     (decimation),
    .trigger_level  (trigger_level),
    .trigger_falling(trigger_falling),
    .vblnk          (vblnk),
    .data_display   (data_display),
    .frame_ready    (frame_ready),
    .capturing      (capturing),
    .auto_triggered (auto_triggered)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;
  int dut_fr = 0;

  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  // reference model: phase 0 armed, 1 capturing, 2 waiting for blank
  int m_phase;
  int m_frame[$];
  int m_disp[256];
  int m_vcnt, m_dec, m_prev, m_arm_n;
  bit m_pv, m_auto, m_vq;
  bit e_fr, e_cap, e_auto;

  always @(posedge clk) begin : ref_model
    int cur, lvl;
    bit acc, hit;
    cur = int'(adc_data);
    lvl = int'(trigger_level);
    if (rst) begin
      m_phase = 0; m_frame.delete();
      m_vcnt = 0; m_dec = int'(decimation);
      m_prev = 0; m_pv = 0; m_arm_n = 0;
      m_auto = 0; m_vq = 0;
      e_fr = 0; e_cap = 0; e_auto = 0;
      for (int i = 0; i < 256; i++) m_disp[i] = 2047;
    end else begin
      acc = 0;
      if (adc_valid) begin
        if (m_vcnt == m_dec) begin
          acc = 1; m_vcnt = 0; m_dec = int'(decimation);
        end else m_vcnt++;
      end
      e_fr = 0;
      if (m_phase == 0) begin
        if (acc) begin
          if (trigger_falling) hit = m_pv && m_prev > lvl && cur <= lvl;
          else                 hit = m_pv && m_prev < lvl && cur >= lvl;
          m_prev = cur; m_pv = 1;
          if (hit || m_arm_n == AUTO - 1) begin
            m_frame.delete();
            m_frame.push_back(cur);
            m_auto = !hit; m_arm_n = 0; m_phase = 1;
          end else m_arm_n++;
        end
      end else if (m_phase == 1) begin
        if (acc) begin
          m_frame.push_back(cur);
          if (m_frame.size() == 256) m_phase = 2;
        end
      end else begin
        if (vblnk && !m_vq) begin
          for (int i = 0; i < 256; i++) m_disp[i] = m_frame[i];
          e_fr = 1; e_auto = m_auto;
          m_auto = 0; m_arm_n = 0; m_phase = 0;
          m_pv = acc;
          if (acc) m_prev = cur;
        end
      end
      m_vq = vblnk;
      e_cap = (m_phase == 1);
    end
  end

  task automatic check_disp(input string tag);
    for (int i = 0; i < 256; i++)
      chk($sformatf("%s_disp[%0d]", tag, i),
          int'(data_display[i]), m_disp[i]);
  endtask

  task automatic cyc(input int d, input bit v, input bit vb);
    adc_data = 12'(d); adc_valid = v; vblnk = vb;
    @(posedge clk); #1;
    if (frame_ready) dut_fr++;
    chk("frame_ready", int'(frame_ready), int'(e_fr));
    chk("capturing", int'(capturing), int'(e_cap));
    chk("auto_triggered", int'(auto_triggered), int'(e_auto));
    if (e_fr) check_disp("swap");
  endtask

  task automatic do_reset(input int dec, input int lvl, input bit fall);
    decimation = 4'(dec);
    trigger_level = 12'(lvl);
    trigger_falling = fall;
    rst = 1'b1;
    cyc(0, 0, 0);
    cyc(0, 0, 0);
    rst = 1'b0;
  endtask

  task automatic pulse_vblnk();
    repeat (2) cyc(0, 0, 0);
    repeat (4) cyc(0, 0, 1);
    repeat (2) cyc(0, 0, 0);
  endtask

  int v, g, f0, d0, dd;

  initial begin
    // idle after reset: midscale, no frames, not capturing
    do_reset(0, 1000, 0);
    repeat (100) cyc(int'($urandom_range(4095)), 0, 0);
    check_disp("idle");
    chk("idle_frames", dut_fr, 0);
    chk("idle_cap", int'(capturing), 0);

    // rising ramp, every sample accepted
    do_reset(0, 1000, 0);
    v = 0; g = 0;
    while (m_phase != 2 && g < 1000) begin
      cyc(v, 1, 0); v = (v + 16) % 4096; g++;
    end
    chk("ramp_done", m_phase, 2);
    f0 = dut_fr;
    repeat (20) begin cyc(v, 1, 0); v = (v + 16) % 4096; end
    pulse_vblnk();
    chk("ramp_swap", dut_fr - f0, 1);
    chk("ramp_idx0", int'(data_display[0]), 1008);
    chk("ramp_idx255", int'(data_display[255]), (1008 + 255 * 16) % 4096);
    chk("ramp_auto", int'(auto_triggered), 0);

    // decimation 3 with gappy valid
    do_reset(3, 1000, 0);
    v = 0; g = 0;
    while (m_phase != 2 && g < 3000) begin
      if ($urandom_range(9) < 7) begin
        cyc(v, 1, 0); v = (v + 7) % 4096;
      end else cyc(int'($urandom_range(4095)), 0, 0);
      g++;
    end
    chk("dec_done", m_phase, 2);
    pulse_vblnk();
    for (int i = 0; i < 4; i++) begin
      dd = (int'(data_display[i + 1]) - int'(data_display[i]) + 4096) % 4096;
      chk($sformatf("dec_step%0d", i), dd, 28);
    end
    d0 = (int'(data_display[255]) - int'(data_display[0]) + 4096) % 4096;
    chk("dec_span", d0, (255 * 28) % 4096);

    // constant input below level: auto-trigger
    do_reset(0, 1000, 0);
    g = 0;
    while (m_phase != 2 && g < 5000) begin cyc(500, 1, 0); g++; end
    chk("auto_done", m_phase, 2);
    pulse_vblnk();
    chk("auto_flag", int'(auto_triggered), 1);
    chk("auto_val0", int'(data_display[0]), 500);
    chk("auto_val255", int'(data_display[255]), 500);

    // falling trigger on a square wave
    do_reset(0, 2047, 1);
    g = 0;
    while (m_phase != 2 && g < 1000) begin
      cyc(((g / 8) % 2) ? 100 : 3000, 1, 0); g++;
    end
    chk("fall_done", m_phase, 2);
    pulse_vblnk();
    chk("fall_idx0", int'(data_display[0]), 100);
    chk("fall_auto", int'(auto_triggered), 0);

    // capture completes with vblnk already high
    do_reset(0, 1000, 0);
    v = 0; g = 0; f0 = dut_fr;
    while (m_phase != 2 && g < 1000) begin
      cyc(v, 1, 1); v = (v + 16) % 4096; g++;
    end
    chk("hold_done", m_phase, 2);
    repeat (300) begin cyc(v, 1, 1); v = (v + 16) % 4096; end
    chk("hold_no_swap", dut_fr - f0, 0);
    repeat (5) begin cyc(v, 1, 0); v = (v + 16) % 4096; end
    repeat (3) begin cyc(v, 1, 1); v = (v + 16) % 4096; end
    chk("hold_swap", dut_fr - f0, 1);

    // reset halfway into the next capture
    g = 0;
    while (!(m_phase == 1 && m_frame.size() == 128) && g < 2000) begin
      cyc(v, 1, 0); v = (v + 16) % 4096; g++;
    end
    chk("mid_reached", m_frame.size(), 128);
    rst = 1'b1;
    cyc(v, 1, 0);
    rst = 1'b0;
    chk("mid_disp0", int'(data_display[0]), 2047);
    chk("mid_disp255", int'(data_display[255]), 2047);
    chk("mid_cap", int'(capturing), 0);
    check_disp("mid");
    g = 0;
    while (m_phase != 2 && g < 2000) begin
      cyc(v, 1, 0); v = (v + 16) % 4096; g++;
    end
    chk("mid_rearm", m_phase, 2);
    pulse_vblnk();

    // rising at level 0 and falling at 4095 can only auto-trigger
    for (int k = 0; k < 2; k++) begin
      do_reset(0, k ? 4095 : 0, k[0]);
      g = 0;
      while (m_phase != 2 && g < 5000) begin
        cyc(int'($urandom_range(4095)), 1, 0); g++;
      end
      chk($sformatf("edge%0d_done", k), m_phase, 2);
      pulse_vblnk();
      chk($sformatf("edge%0d_auto", k), int'(auto_triggered), 1);
    end

    // randomized soak with periodic blanking
    do_reset(int'($urandom_range(2)), int'($urandom_range(4095)),
             1'($urandom_range(1)));
    for (int n = 0; n < 20000; n++) begin
      if (n % 4000 == 0) begin
        decimation = 4'($urandom_range(3));
        trigger_level = 12'($urandom_range(4095));
        trigger_falling = 1'($urandom_range(1));
      end
      cyc(int'($urandom_range(4095)), $urandom_range(3) != 0,
          (n % 500) >= 470);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
